qpsk_symbol_mapper: RTL

QPSK_SYMBOL_MAPPER -- requirements
Module: qpsk_symbol_mapper

---
 rtl/qpsk_symbol_mapper.sv | 117 +++++++++++
 1 files changed

// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper: captures one 4-bit I word and one 4-bit Q word, then emits
// four symbols of +/-AMP, each held SYM_LEN clocks, followed by a one-cycle frame_done.
module qpsk_symbol_mapper #(
   parameter int SYM_LEN = 8,
   parameter int AMP     = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        eve_word,
   input  logic [3:0]        odd_word,
   input  logic              eve_valid,
   input  logic              odd_valid,
   output logic              ack,
   output logic signed [7:0] i_level,
   output logic signed [7:0] q_level,
   output logic              sym_valid,
   output logic [1:0]        sym_index,
   output logic              busy,
   output logic              frame_done
);

   localparam int              CW       = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SYM_LEN - 1);
   localparam logic signed [7:0] LVL_POS = 8'(AMP);
   localparam logic signed [7:0] LVL_NEG = 8'(-AMP);

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    eve_q, eve_d;
   logic [3:0]    odd_q, odd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          capture;

   function automatic logic signed [7:0] map_bit(input logic b);
      return b ? LVL_NEG : LVL_POS;
   endfunction

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      eve_d   = eve_q;
      odd_d   = odd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (eve_valid && odd_valid) begin
               capture = 1'b1;
               eve_d   = eve_word;
               odd_d   = odd_word;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         eve_q   <= '0;
         odd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         eve_q   <= eve_d;
         odd_q   <= odd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Output stage decodes the current state, so levels trail the capture edge by one clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack        <= 1'b0;
         i_level    <= '0;
         q_level    <= '0;
         sym_valid  <= 1'b0;
         sym_index  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ack        <= capture;
         sym_valid  <= (state_q == EMIT);
         busy       <= (state_q != IDLE);
         frame_done <= (state_q == DONE);
         if (state_q == EMIT) begin
            i_level   <= map_bit(eve_q[idx_q]);
            q_level   <= map_bit(odd_q[idx_q]);
            sym_index <= idx_q;
         end else begin
            i_level   <= '0;
            q_level   <= '0;
            sym_index <= '0;
         end
      end
   end

endmodule
